// File: rtl/rv_writeback_ld.sv
// Writeback stage for the uRV pipeline: ALU results retire combinationally, loads wait
// for variable-latency data memory with alignment, misalignment and timeout handling.
module rv_writeback_ld #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 w_stall_i,
    input  logic                 x_valid_i,
    output logic                 x_ready_o,
    input  logic                 x_load_i,
    input  logic [2:0]           x_fun_i,
    input  logic [XLEN-1:0]      x_dm_addr_i,
    input  logic [RF_ADDR_W-1:0] x_rd_i,
    input  logic [XLEN-1:0]      x_rd_value_i,
    input  logic                 x_rd_write_i,
    input  logic                 dm_load_done_i,
    input  logic [XLEN-1:0]      dm_data_l_i,
    output logic [XLEN-1:0]      rf_rd_value_o,
    output logic [RF_ADDR_W-1:0] rf_rd_o,
    output logic                 rf_rd_write_o,
    output logic                 w_load_pending_o,
    output logic                 w_misaligned_o,
    output logic                 w_timeout_o
);

    localparam int LB = $clog2(XLEN / 8);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state, state_nxt;
    logic [TIMEOUT_W-1:0]   cnt, cnt_nxt;
    logic [RF_ADDR_W-1:0]   hold_rd, hold_rd_nxt;
    logic [2:0]             hold_fun, hold_fun_nxt;
    logic [LB-1:0]          hold_off, hold_off_nxt;
    logic                   held_valid, held_valid_nxt;
    logic [XLEN-1:0]        held_data, held_data_nxt;

    logic                   ready;
    logic                   acc;
    logic [XLEN-1:0]        x_aligned;
    logic [XLEN-1:0]        w_aligned;

    function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] data,
                                                   input logic [2:0]      fun,
                                                   input logic [LB-1:0]   off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        logic            fill;
        int unsigned     w;
        sh = data >> {off, 3'b000};
        case (fun[1:0])
            2'b00:   w = 8;
            2'b01:   w = 16;
            2'b10:   w = 32;
            default: w = XLEN;
        endcase
        fill = 1'b0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (!fun[2] && (i + 1 == w)) fill = sh[i];
        end
        res = sh;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i >= w) res[i] = fill;
        end
        return res;
    endfunction

    // Illegal widths for the configured XLEN are folded into the misaligned path.
    function automatic logic is_misaligned(input logic [2:0] fun, input logic [XLEN-1:0] addr);
        logic bad;
        case (fun)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = |addr[1:0];
            3'b110:         bad = (|addr[1:0]) || (XLEN == 32);
            3'b011:         bad = (|addr[2:0]) || (XLEN == 32);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign ready     = (state == IDLE);
    assign acc       = x_valid_i & ready & ~w_stall_i & ~rst_i;
    assign x_aligned = align_load(dm_data_l_i, x_fun_i, x_dm_addr_i[LB-1:0]);
    assign w_aligned = align_load(dm_data_l_i, hold_fun, hold_off);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_rd    <= '0;
            hold_fun   <= '0;
            hold_off   <= '0;
            held_valid <= 1'b0;
            held_data  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hold_rd    <= hold_rd_nxt;
            hold_fun   <= hold_fun_nxt;
            hold_off   <= hold_off_nxt;
            held_valid <= held_valid_nxt;
            held_data  <= held_data_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        hold_rd_nxt      = hold_rd;
        hold_fun_nxt     = hold_fun;
        hold_off_nxt     = hold_off;
        held_valid_nxt   = held_valid;
        held_data_nxt    = held_data;
        x_ready_o        = ready;
        w_load_pending_o = (state == WAIT);
        rf_rd_o          = x_rd_i;
        rf_rd_value_o    = x_rd_value_i;
        rf_rd_write_o    = 1'b0;
        w_misaligned_o   = 1'b0;
        w_timeout_o      = 1'b0;

        case (state)
            IDLE: begin
                if (x_load_i && dm_load_done_i) rf_rd_value_o = x_aligned;
                if (acc) begin
                    if (!x_load_i) begin
                        rf_rd_write_o = x_rd_write_i & (x_rd_i != '0);
                    end else if (is_misaligned(x_fun_i, x_dm_addr_i)) begin
                        w_misaligned_o = 1'b1;
                    end else if (dm_load_done_i) begin
                        rf_rd_write_o = (x_rd_i != '0);
                    end else begin
                        hold_rd_nxt    = x_rd_i;
                        hold_fun_nxt   = x_fun_i;
                        hold_off_nxt   = x_dm_addr_i[LB-1:0];
                        held_valid_nxt = 1'b0;
                        cnt_nxt        = '0;
                        state_nxt      = WAIT;
                    end
                end
            end
            WAIT: begin
                rf_rd_o       = hold_rd;
                rf_rd_value_o = held_valid ? held_data : w_aligned;
                // Data returned under stall is parked and retried; it also cancels the timeout.
                if (held_valid || dm_load_done_i) begin
                    if (!w_stall_i) begin
                        rf_rd_write_o = (hold_rd != '0);
                        state_nxt     = IDLE;
                    end else if (!held_valid) begin
                        held_valid_nxt = 1'b1;
                        held_data_nxt  = w_aligned;
                    end
                end else if (cnt == '1) begin
                    w_timeout_o = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (w_stall_i) rf_rd_write_o = 1'b0;
        if (rst_i) begin
            rf_rd_write_o  = 1'b0;
            rf_rd_o        = '0;
            rf_rd_value_o  = '0;
            w_misaligned_o = 1'b0;
            w_timeout_o    = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_writeback_ld.sv
// Scoreboard bench for rv_writeback_ld: a 32-bit and a 64-bit instance driven in turn,
// expected RF writes and pulses queued by a reference model and checked by a monitor.
module tb_rv_writeback_ld;

    localparam int TW   = 3;
    localparam int TMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, x_valid, x_load, x_rd_write, dm_done;
    logic [2:0]  x_fun;
    logic [63:0] x_addr, x_val, dm_data;
    logic [4:0]  x_rd;
    int          sel;

    logic v0, v1, dn0, dn1;
    assign v0  = x_valid & (sel == 0);
    assign v1  = x_valid & (sel == 1);
    assign dn0 = dm_done & (sel == 0);
    assign dn1 = dm_done & (sel == 1);

    logic        ready0, pend0, mis0, tmo0, we0;
    logic [4:0]  rd0;
    logic [31:0] val0;
    logic        ready1, pend1, mis1, tmo1, we1;
    logic [4:0]  rd1;
    logic [63:0] val1;

    rv_writeback_ld #(.XLEN(32), .RF_ADDR_W(5), .TIMEOUT_W(TW)) dut32 (
        .clk_i(clk), .rst_i(rst), .w_stall_i(stall),
        .x_valid_i(v0), .x_ready_o(ready0), .x_load_i(x_load), .x_fun_i(x_fun),
        .x_dm_addr_i(x_addr[31:0]), .x_rd_i(x_rd), .x_rd_value_i(x_val[31:0]),
        .x_rd_write_i(x_rd_write), .dm_load_done_i(dn0), .dm_data_l_i(dm_data[31:0]),
        .rf_rd_value_o(val0), .rf_rd_o(rd0), .rf_rd_write_o(we0),
        .w_load_pending_o(pend0), .w_misaligned_o(mis0), .w_timeout_o(tmo0));

    rv_writeback_ld #(.XLEN(64), .RF_ADDR_W(5), .TIMEOUT_W(TW)) dut64 (
        .clk_i(clk), .rst_i(rst), .w_stall_i(stall),
        .x_valid_i(v1), .x_ready_o(ready1), .x_load_i(x_load), .x_fun_i(x_fun),
        .x_dm_addr_i(x_addr), .x_rd_i(x_rd), .x_rd_value_i(x_val),
        .x_rd_write_i(x_rd_write), .dm_load_done_i(dn1), .dm_data_l_i(dm_data),
        .rf_rd_value_o(val1), .rf_rd_o(rd1), .rf_rd_write_o(we1),
        .w_load_pending_o(pend1), .w_misaligned_o(mis1), .w_timeout_o(tmo1));

    // kind: 1 = RF write, 2 = misaligned pulse, 4 = timeout pulse
    typedef struct {
        int          kind;
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] val;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d, cycle %0d): got 0x%0h, want 0x%0h", name, sel, cyc, act, exp);
        end
    endtask

    function automatic int xlen_of(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic bit ref_bad(input int xl, input logic [2:0] f, input logic [63:0] a);
        longint unsigned size;
        if (f == 3'd7) return 1'b1;
        if (xl == 32 && (f == 3'd3 || f == 3'd6)) return 1'b1;
        size = 64'd1 << f[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [63:0] ref_val(input int xl, input logic [2:0] f,
                                            input logic [63:0] a, input logic [63:0] data);
        longint unsigned lane, sb, v, mask;
        lane = a % longint'(xl / 8);
        sb   = 8 * (64'd1 << f[1:0]);
        v    = data >> (8 * lane);
        mask = (sb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sb) - 1);
        v    = v & mask;
        if (!f[2] && sb < longint'(xl) && v[sb-1]) v = v | ~mask;
        if (xl == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic rdy_of(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    function automatic logic pend_of(input int d);
        return (d == 0) ? pend0 : pend1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input int kind, input int c, input logic [4:0] rd,
                        input logic [63:0] val);
        ev_t e;
        e.kind = kind; e.cyc = c; e.rd = rd; e.val = val;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic we, input logic mis, input logic tmo,
                       input logic [4:0] rd, input logic [63:0] val);
        int  k;
        ev_t e;
        k = int'({tmo, mis, we});
        if (k != 0) begin
            if (qsize(d) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected event (dut%0d, cycle %0d): got kind %0d rd %0d val 0x%0h, want none",
                         d, cyc, k, rd, val);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("event kind", 64'(k), 64'(e.kind));
                chk("event cycle", 64'(cyc), 64'(e.cyc));
                if (e.kind == 1) begin
                    chk("write rd", 64'(rd), 64'(e.rd));
                    chk("write value", val, e.val);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, we0, mis0, tmo0, rd0, {32'b0, val0});
            mon(1, we1, mis1, tmo1, rd1, val1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_valid = 1'b0; x_load = 1'b0; x_rd_write = 1'b0; dm_done = 1'b0; stall = 1'b0;
    endtask

    task automatic alu(input int d, input logic [4:0] rd, input logic [63:0] val,
                       input logic we, input logic st);
        sel = d;
        chk("ready before alu", 64'(rdy_of(d)), 64'd1);
        x_valid = 1'b1; x_load = 1'b0; x_rd = rd; x_val = val; x_rd_write = we; stall = st;
        if (we && rd != 0 && !st)
            push(d, 1, cyc, rd, (xlen_of(d) == 32) ? (val & 64'hFFFF_FFFF) : val);
        step();
        idle_inputs();
        chk("queue drained after alu", 64'(qsize(d)), 64'd0);
    endtask

    // dly = 0: data with the request; dly = n: data in the n-th wait cycle; st = stall cycles at data
    task automatic load(input int d, input logic [4:0] rd, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] data, input int dly, input int st);
        int xl, c0, done_k;
        xl = xlen_of(d);
        sel = d;
        chk("ready before load", 64'(rdy_of(d)), 64'd1);
        x_valid = 1'b1; x_load = 1'b1; x_fun = f; x_addr = a; x_rd = rd;
        dm_data = data; dm_done = (dly == 0); stall = 1'b0;
        if (ref_bad(xl, f, a)) begin
            push(d, 2, cyc, 5'd0, 64'd0);
            step();
            idle_inputs();
            chk("ready after misaligned", 64'(rdy_of(d)), 64'd1);
            chk("pending after misaligned", 64'(pend_of(d)), 64'd0);
        end else if (dly == 0) begin
            if (rd != 0) push(d, 1, cyc, rd, ref_val(xl, f, a, data));
            step();
            idle_inputs();
            chk("ready after direct load", 64'(rdy_of(d)), 64'd1);
        end else begin
            c0 = cyc;
            done_k = dly - 1;
            if (done_k <= TMAX) begin
                if (rd != 0) push(d, 1, c0 + 1 + done_k + st, rd, ref_val(xl, f, a, data));
            end else begin
                push(d, 4, c0 + 1 + TMAX, 5'd0, 64'd0);
            end
            step();
            // an ALU op offered during WAIT must be ignored
            x_load = 1'b0; x_valid = 1'b1; x_rd_write = 1'b1;
            x_rd = 5'($urandom_range(1, 31)); x_val = {$urandom, $urandom}; dm_done = 1'b0;
            for (int k = 0; k <= TMAX; k++) begin
                chk("ready in wait", 64'(rdy_of(d)), 64'd0);
                chk("pending in wait", 64'(pend_of(d)), 64'd1);
                if (k == done_k) begin
                    dm_done = 1'b1;
                    stall = (st > 0);
                    for (int j = 1; j <= st; j++) begin
                        step();
                        dm_done = 1'b0;
                        dm_data = {$urandom, $urandom};
                        stall = (j < st);
                        chk("pending while stalled", 64'(pend_of(d)), 64'd1);
                    end
                    break;
                end
                if (k == TMAX) break;
                step();
            end
            step();
            idle_inputs();
            chk("ready after load", 64'(rdy_of(d)), 64'd1);
            chk("pending after load", 64'(pend_of(d)), 64'd0);
        end
        chk("queue drained after load", 64'(qsize(d)), 64'd0);
    endtask

    task automatic rst_mid_wait(input int d);
        sel = d;
        x_valid = 1'b1; x_load = 1'b1; x_fun = 3'd2; x_addr = 64'h0; x_rd = 5'd17;
        dm_done = 1'b0; stall = 1'b0;
        step();
        idle_inputs();
        x_rd = 5'd17;
        step();
        step();
        chk("pending before reset", 64'(pend_of(d)), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ready in reset", 64'(rdy_of(d)), 64'd1);
        chk("pending in reset", 64'(pend_of(d)), 64'd0);
        chk("rf write in reset", 64'(d == 0 ? we0 : we1), 64'd0);
        chk("rf rd in reset", 64'(d == 0 ? rd0 : rd1), 64'd0);
        chk("timeout in reset", 64'(d == 0 ? tmo0 : tmo1), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < TMAX + 2; i++) step();
        chk("pending after reset", 64'(pend_of(d)), 64'd0);
        chk("no events after reset", 64'(qsize(d)), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [63:0] a;
        int          d;
        rst = 1'b1; sel = 0; x_fun = 3'd0; x_addr = '0; x_val = '0; dm_data = '0; x_rd = 5'd3;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready32", 64'(ready0), 64'd1);
        chk("reset ready64", 64'(ready1), 64'd1);
        chk("reset outs32", {59'd0, pend0, mis0, tmo0, we0, |rd0}, 64'd0);
        chk("reset outs64", {59'd0, pend1, mis1, tmo1, we1, |rd1}, 64'd0);
        chk("reset value32", 64'(val0), 64'd0);
        rst = 1'b0;
        step();

        alu(0, 5'd5, 64'h1234, 1'b1, 1'b0);
        alu(0, 5'd0, 64'h1234, 1'b1, 1'b0);
        alu(0, 5'd6, 64'h55AA, 1'b1, 1'b1);
        load(0, 5'd7, 3'd0, 64'h3, 64'h80FF_0000, 0, 0);
        load(0, 5'd7, 3'd4, 64'h3, 64'h80FF_0000, 0, 0);
        load(0, 5'd9, 3'd1, 64'h2, 64'h7FFF_0001, 3, 0);
        load(0, 5'd9, 3'd2, 64'h2, 64'h1, 0, 0);
        load(0, 5'd9, 3'd3, 64'h0, 64'h1, 0, 0);
        load(0, 5'd9, 3'd6, 64'h0, 64'h1, 2, 0);
        load(0, 5'd9, 3'd7, 64'h0, 64'h1, 2, 0);
        load(0, 5'd10, 3'd2, 64'h0, 64'hDEAD_BEEF, 99, 0);
        load(0, 5'd10, 3'd2, 64'h0, 64'hDEAD_BEEF, TMAX, 0);
        load(0, 5'd10, 3'd2, 64'h0, 64'hCAFE_F00D, TMAX + 1, 0);
        load(1, 5'd11, 3'd6, 64'h4, 64'h8000_0000_0000_0000, 2, 0);
        load(1, 5'd11, 3'd6, 64'h4, 64'h8000_0000_0000_0000, 1, 2);
        load(1, 5'd12, 3'd3, 64'h8, 64'hFEDC_BA98_7654_3210, 0, 0);
        load(1, 5'd12, 3'd2, 64'h4, 64'h8765_4321_0000_0000, TMAX + 1, 1);
        load(1, 5'd0, 3'd0, 64'h1, 64'h0000_0000_0000_8000, 2, 0);
        rst_mid_wait(1);

        for (int n = 0; n < 120; n++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                alu(d, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom),
                    ($urandom_range(0, 3) == 0));
            end else begin
                f = 3'($urandom_range(0, 7));
                a = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 1);
                load(d, 5'($urandom_range(0, 31)), f, a, {$urandom, $urandom},
                     int'($urandom_range(0, TMAX + 3)), int'($urandom_range(0, 2)));
            end
        end

        chk("final queue32 empty", 64'(q0.size()), 64'd0);
        chk("final queue64 empty", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_writeback_ld.md
Name: rv_writeback_ld

Overview:
Parametrised writeback stage for the uRV pipeline. It supports variable-latency data memory, XLEN of 32 or 64, misalignment detection and a load timeout. It sits between execute and the register file. ALU results retire combinationally. Loads are tracked by a small FSM that holds the destination until memory returns data, and back-pressures execute while doing so.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
RF_ADDR_W, 5, register-file index width
TIMEOUT_W, 8, width of the load-wait counter; a timeout fires after 2**TIMEOUT_W-1 wait cycles

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
w_stall_i  in  1  global stall; suppresses any RF write this cycle
x_valid_i  in  1  execute presents an instruction to retire
x_ready_o  out  1  writeback accepts x_valid_i this cycle
x_load_i  in  1  instruction is a load
x_fun_i  in  3  load width, RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
x_dm_addr_i  in  XLEN  load byte address; only the low log2(XLEN/8) bits are used
x_rd_i  in  RF_ADDR_W  destination register
x_rd_value_i  in  XLEN  ALU result
x_rd_write_i  in  1  ALU result writes rd
dm_load_done_i  in  1  memory load data valid
dm_data_l_i  in  XLEN  memory read word
rf_rd_value_o  out  XLEN  RF write data
rf_rd_o  out  RF_ADDR_W  RF write index
rf_rd_write_o  out  1  RF write enable
w_load_pending_o  out  1  FSM is in WAIT
w_misaligned_o  out  1  one-cycle pulse: misaligned load dropped
w_timeout_o  out  1  one-cycle pulse: load abandoned after timeout

Behaviour:
- Reset state: FSM = IDLE, wait counter = 0, held rd/fun/offset = 0. All outputs are 0 except x_ready_o, which is 1.
- Accept condition: acc = x_valid_i & x_ready_o & ~w_stall_i.
- x_ready_o = (state == IDLE).

FSM, IDLE:
- acc & ~x_load_i: rf_rd_write_o = x_rd_write_i & (x_rd_i != 0). rf_rd_value_o = x_rd_value_i, same cycle, zero latency.
- acc & x_load_i & misaligned: no write; w_misaligned_o = 1 for one cycle; stay in IDLE.
- Misaligned means: H/HU with addr[0] != 0; W/WU with addr[1:0] != 0; D with addr[2:0] != 0.
- Illegal loads: D and WU when XLEN = 32, and funct3 111, are treated as misaligned.
- acc & x_load_i & dm_load_done_i: complete the load in the same cycle and stay in IDLE.
- acc & x_load_i, no done: capture rd, fun and the address offset; clear the counter; go to WAIT.

FSM, WAIT:
- x_ready_o = 0; w_load_pending_o = 1; the counter increments each cycle.
- dm_load_done_i & ~w_stall_i: write the aligned value to the held rd (suppressed when rd = 0); go to IDLE.
- dm_load_done_i & w_stall_i: the data is not written and is not lost. The aligned value is registered and the write retries in the first non-stalled cycle; the FSM stays in WAIT until then.
- Counter reaches all-ones without done: w_timeout_o pulses; no write; go to IDLE.
- dm_load_done_i arriving in the same cycle as the timeout: done wins and no timeout is flagged.

Alignment:
- Byte lane = offset[log2(XLEN/8)-1:0].
- B/H/W: sign-extend the selected lane to XLEN.
- BU/HU/WU: zero-extend the selected lane to XLEN.
- D: full word.

Other rules:
- w_stall_i forces rf_rd_write_o = 0 in every state.
- Reset asserted mid-WAIT aborts the load with no write and no pulse.
- rf_rd_o always reflects the held rd in WAIT and x_rd_i in IDLE.

Test Plan:
1. XLEN=32. ALU op: x_valid_i=1, x_rd_i=5, x_rd_value_i=0x1234, x_rd_write_i=1 -> same cycle rf_rd_write_o=1, rf_rd_o=5, value 0x1234. Repeat with rd=0 -> rf_rd_write_o=0.
2. LB at addr 0x...3 with dm_data_l_i=0x80FF_0000 and done in the same cycle -> value 0xFFFF_FF80, no WAIT. Repeat as LBU -> 0x0000_0080.
3. LH at addr 0x2 with done after 3 cycles and data 0x7FFF_0001 -> x_ready_o low for 3 cycles, w_load_pending_o high, then write 0x0000_7FFF to the held rd. Issue an ALU op during WAIT -> it is not accepted.
4. LW at addr 0x2 -> w_misaligned_o pulses once, no write, x_ready_o stays 1. XLEN=32 with funct3=011 -> misaligned pulse.
5. TIMEOUT_W=3, load with no done -> w_timeout_o pulses after 7 wait cycles, FSM returns to IDLE, no write. Done on the 7th cycle -> write, no timeout.
6. XLEN=64: LWU at addr 0x4 with data 0x8000_0000_0000_0000 -> 0x0000_0000_8000_0000. Done while w_stall_i=1 for 2 cycles -> write occurs on the first unstalled cycle with the same value. Assert rst_i mid-WAIT -> outputs return to reset values asynchronously.
